fetch_stage: RTL and testbench

- Instruction-fetch stage plus IF/ID pipeline register for the 5-stage RV32I core.
- Owns the fetch PC and the instruction-memory request/response handshake.
- Obeys stallF/stallD/flushD from the hazard unit and redirects on wrongBranchE.
- Feeds instrD, pcD and pcPlus4D to decode. Inserts NOP bubbles when memory has no instruction ready.

---
 rtl/fetch_stage.sv | 159 +++++++++++++++
 tb/tb_fetch_stage.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// Instruction-fetch stage and IF/ID pipeline register for the 5-stage RV32I core.
// Owns the fetch PC, runs a single-outstanding request/response handshake with
// instruction memory, buffers one delivered instruction while decode is stalled,
// and squashes wrong-path fetches when execute reports a mispredicted branch.
module fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rstN,
    input  logic        stallF,
    input  logic        stallD,
    input  logic        flushD,
    input  logic        wrongBranchE,
    input  logic [31:0] pcTargetE,
    output logic        imemReq,
    output logic [31:0] imemAddr,
    input  logic        imemGnt,
    input  logic        imemRvalid,
    input  logic [31:0] imemRdata,
    output logic [31:0] instrD,
    output logic [31:0] pcD,
    output logic [31:0] pcPlus4D,
    output logic        validD,
    output logic        fetchBusyF
);

    // ISSUE: free to request; WAIT: response owed for a live request;
    // DROP: response owed for a request squashed by a redirect.
    typedef enum logic [1:0] {
        ST_ISSUE = 2'd0,
        ST_WAIT  = 2'd1,
        ST_DROP  = 2'd2
    } state_t;

    state_t      state;
    logic [31:0] pc_f;
    logic [31:0] req_pc_p0;
    logic        skid_vld_p0;
    logic [31:0] skid_instr_p0;
    logic [31:0] skid_pc_p0;

    logic        fire;
    logic        resp_live;
    logic        resp_deliver;
    logic        avail;
    logic [31:0] avail_instr;
    logic [31:0] avail_pc;
    logic [31:0] target_aligned;

    // Request depends only on registered state and stallF, never on the response
    // side, so there is no imemRvalid/imemRdata -> imemReq/imemAddr path.
    assign imemReq    = rstN && (state == ST_ISSUE) && !stallF && !skid_vld_p0;
    assign imemAddr   = pc_f;
    assign fire       = imemReq && imemGnt;
    assign fetchBusyF = (state == ST_WAIT) || (state == ST_DROP);

    // Low target bits are dropped so every fetch address stays word aligned.
    assign target_aligned = pcTargetE & 32'hFFFF_FFFC;

    // A response for a live request; a same-cycle redirect makes it wrong-path.
    assign resp_live    = (state == ST_WAIT) && imemRvalid;
    assign resp_deliver = resp_live && !wrongBranchE;

    // The skid entry is older than anything memory could return, so it wins.
    assign avail       = !wrongBranchE && (skid_vld_p0 || resp_deliver);
    assign avail_instr = skid_vld_p0 ? skid_instr_p0 : imemRdata;
    assign avail_pc    = skid_vld_p0 ? skid_pc_p0    : req_pc_p0;

    // Handshake FSM and fetch PC; redirect takes precedence over any stall.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state <= ST_ISSUE;
            pc_f  <= RESET_PC;
        end else begin
            case (state)
                ST_ISSUE: begin
                    if (fire) begin
                        state <= wrongBranchE ? ST_DROP : ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (imemRvalid) begin
                        state <= ST_ISSUE;
                    end else if (wrongBranchE) begin
                        state <= ST_DROP;
                    end
                end
                ST_DROP: begin
                    if (imemRvalid) begin
                        state <= ST_ISSUE;
                    end
                end
                default: state <= ST_ISSUE;
            endcase

            if (wrongBranchE) begin
                pc_f <= target_aligned;
            end else if (resp_live) begin
                pc_f <= req_pc_p0 + 32'd4;
            end
        end
    end

    // Remember which PC the outstanding request was issued for.
    always_ff @(posedge clk) begin
        if (fire) begin
            req_pc_p0 <= pc_f;
        end
    end

    // Skid occupancy: filled by a delivery that decode cannot take, drained
    // once decode is free, cleared by a redirect.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            skid_vld_p0 <= 1'b0;
        end else if (wrongBranchE) begin
            skid_vld_p0 <= 1'b0;
        end else if (skid_vld_p0) begin
            if (!stallD) begin
                skid_vld_p0 <= 1'b0;
            end
        end else if (resp_deliver && stallD) begin
            skid_vld_p0 <= 1'b1;
        end
    end

    // Skid payload captured alongside the occupancy flag.
    always_ff @(posedge clk) begin
        if (!skid_vld_p0 && resp_deliver && stallD) begin
            skid_instr_p0 <= imemRdata;
            skid_pc_p0    <= req_pc_p0;
        end
    end

    // IF/ID register: flush beats stall beats load; otherwise insert a bubble.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            instrD   <= NOP_INSTR;
            pcD      <= 32'd0;
            pcPlus4D <= 32'd4;
            validD   <= 1'b0;
        end else if (flushD) begin
            instrD <= NOP_INSTR;
            validD <= 1'b0;
        end else if (stallD) begin
            instrD <= instrD;
        end else if (avail) begin
            instrD   <= avail_instr;
            pcD      <= avail_pc;
            pcPlus4D <= avail_pc + 32'd4;
            validD   <= 1'b1;
        end else begin
            instrD <= NOP_INSTR;
            validD <= 1'b0;
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: hand-derived cycle table, asynchronous reset in the
// middle of a request, then randomized traffic against a reference model.
module tb_fetch_stage;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rstN;
    logic        stallF, stallD, flushD, wrongBranchE;
    logic [31:0] pcTargetE;
    logic        imemReq;
    logic [31:0] imemAddr;
    logic        imemGnt, imemRvalid;
    logic [31:0] imemRdata;
    logic [31:0] instrD, pcD, pcPlus4D;
    logic        validD, fetchBusyF;

    fetch_stage #(.RESET_PC(32'h0000_0000), .NOP_INSTR(NOP)) dut (
        .clk(clk), .rstN(rstN), .stallF(stallF), .stallD(stallD), .flushD(flushD),
        .wrongBranchE(wrongBranchE), .pcTargetE(pcTargetE),
        .imemReq(imemReq), .imemAddr(imemAddr), .imemGnt(imemGnt),
        .imemRvalid(imemRvalid), .imemRdata(imemRdata),
        .instrD(instrD), .pcD(pcD), .pcPlus4D(pcPlus4D), .validD(validD),
        .fetchBusyF(fetchBusyF)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- cycle table ----------------
    typedef struct {
        logic        sf, sd, fl, wb;
        logic [31:0] tgt;
        logic        gnt, rv;
        logic [31:0] rd;
        logic        e_req;
        logic [31:0] e_addr, e_instr, e_pc;
        logic        e_vld, e_busy;
    } vec_t;

    function automatic vec_t mk(input logic sf, sd, fl, wb, input logic [31:0] tgt,
                                input logic gnt, rv, input logic [31:0] rd,
                                input logic e_req, input logic [31:0] e_addr, e_instr, e_pc,
                                input logic e_vld, e_busy);
        vec_t v;
        v.sf = sf; v.sd = sd; v.fl = fl; v.wb = wb; v.tgt = tgt;
        v.gnt = gnt; v.rv = rv; v.rd = rd;
        v.e_req = e_req; v.e_addr = e_addr; v.e_instr = e_instr; v.e_pc = e_pc;
        v.e_vld = e_vld; v.e_busy = e_busy;
        return v;
    endfunction

    vec_t tbl[18];

    // ---------------- reference model ----------------
    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
    } fetched_t;

    logic [31:0] m_pc, m_reqpc, m_instr, m_pcd;
    logic        m_busy, m_drop, m_vld;
    fetched_t    m_skid[$];

    task automatic model_reset();
        m_pc = 32'h0; m_reqpc = 32'h0; m_busy = 1'b0; m_drop = 1'b0;
        m_instr = NOP; m_pcd = 32'h0; m_vld = 1'b0;
        m_skid.delete();
    endtask

    function automatic logic model_req(input logic sf);
        return !m_busy && !sf && (m_skid.size() == 0);
    endfunction

    task automatic model_step(input logic sf, sd, fl, wb, input logic [31:0] tgt,
                              input logic gnt, rv, input logic [31:0] rd);
        fetched_t got;
        logic have, live, fresh, fire;
        live  = m_busy && !m_drop && rv;
        fresh = live && !wb;
        fire  = model_req(sf) && gnt;
        have  = 1'b0;
        got.instr = 32'h0; got.pc = 32'h0;
        if (!wb) begin
            if (m_skid.size() > 0) begin
                got = m_skid[0]; have = 1'b1;
            end else if (fresh) begin
                got.instr = rd; got.pc = m_reqpc; have = 1'b1;
            end
        end
        if (fl) begin
            m_instr = NOP; m_vld = 1'b0;
        end else if (!sd) begin
            if (have) begin
                m_instr = got.instr; m_pcd = got.pc; m_vld = 1'b1;
            end else begin
                m_instr = NOP; m_vld = 1'b0;
            end
        end
        if (wb) m_skid.delete();
        else if (m_skid.size() > 0) begin
            if (!sd) void'(m_skid.pop_front());
        end else if (fresh && sd) m_skid.push_back(got);
        if (wb) m_pc_next(tgt & 32'hFFFF_FFFC, fire);
        else if (live) m_pc_next(m_reqpc + 32'd4, fire);
        else m_pc_next(m_pc, fire);
        if (fire) begin
            m_busy = 1'b1; m_drop = wb;
        end else if (m_busy) begin
            if (rv) begin
                m_busy = 1'b0; m_drop = 1'b0;
            end else if (wb) m_drop = 1'b1;
        end
    endtask

    // Request PC is the address presented this cycle, taken before the PC moves.
    task automatic m_pc_next(input logic [31:0] nxt, input logic fire);
        if (fire) m_reqpc = m_pc;
        m_pc = nxt;
    endtask

    task automatic check_model(input string tag);
        chk1 ({tag, ".imemReq"},    imemReq,    model_req(stallF));
        chk32({tag, ".imemAddr"},   imemAddr,   m_pc);
        chk1 ({tag, ".fetchBusyF"}, fetchBusyF, m_busy);
        chk32({tag, ".instrD"},     instrD,     m_instr);
        chk32({tag, ".pcD"},        pcD,        m_pcd);
        chk32({tag, ".pcPlus4D"},   pcPlus4D,   m_pcd + 32'd4);
        chk1 ({tag, ".validD"},     validD,     m_vld);
    endtask

    task automatic drive_idle();
        stallF = 0; stallD = 0; flushD = 0; wrongBranchE = 0; pcTargetE = 32'h0;
        imemGnt = 0; imemRvalid = 0; imemRdata = 32'h0;
    endtask

    task automatic check_reset_vals(input string tag);
        chk1 ({tag, ".imemReq"},    imemReq,    1'b0);
        chk32({tag, ".instrD"},     instrD,     NOP);
        chk32({tag, ".pcD"},        pcD,        32'h0);
        chk32({tag, ".pcPlus4D"},   pcPlus4D,   32'h4);
        chk1 ({tag, ".validD"},     validD,     1'b0);
        chk1 ({tag, ".fetchBusyF"}, fetchBusyF, 1'b0);
    endtask

    initial begin
        logic        sf, sd, fl, wb, gnt, rv, fire_pred, mem_pending;
        logic [31:0] tgt, rd;
        int          mem_cnt;

        tbl[0]  = mk(0,0,0,0,32'h0,  1,0,32'h0,        1,32'h000,NOP,         32'h000,0,0);
        tbl[1]  = mk(0,0,0,0,32'h0,  1,1,32'h00100093, 0,32'h000,NOP,         32'h000,0,1);
        tbl[2]  = mk(0,0,0,0,32'h0,  1,0,32'h0,        1,32'h004,32'h00100093,32'h000,1,0);
        tbl[3]  = mk(0,0,0,0,32'h0,  1,1,32'h00200113, 0,32'h004,NOP,         32'h000,0,1);
        tbl[4]  = mk(0,0,0,0,32'h0,  0,0,32'h0,        1,32'h008,32'h00200113,32'h004,1,0);
        tbl[5]  = mk(0,0,0,0,32'h0,  0,0,32'h0,        1,32'h008,NOP,         32'h004,0,0);
        tbl[6]  = mk(0,0,0,0,32'h0,  1,0,32'h0,        1,32'h008,NOP,         32'h004,0,0);
        tbl[7]  = mk(0,1,0,0,32'h0,  0,1,32'h00A00093, 0,32'h008,NOP,         32'h004,0,1);
        tbl[8]  = mk(0,1,0,0,32'h0,  1,0,32'h0,        0,32'h00C,NOP,         32'h004,0,0);
        tbl[9]  = mk(0,0,0,0,32'h0,  1,0,32'h0,        0,32'h00C,NOP,         32'h004,0,0);
        tbl[10] = mk(0,0,0,0,32'h0,  1,0,32'h0,        1,32'h00C,32'h00A00093,32'h008,1,0);
        tbl[11] = mk(0,0,0,1,32'h203,0,0,32'h0,        0,32'h00C,NOP,         32'h008,0,1);
        tbl[12] = mk(0,0,0,0,32'h0,  0,1,32'hDEADBEEF, 0,32'h200,NOP,         32'h008,0,1);
        tbl[13] = mk(0,0,0,0,32'h0,  1,0,32'h0,        1,32'h200,NOP,         32'h008,0,0);
        tbl[14] = mk(0,0,0,0,32'h0,  0,1,32'h00300193, 0,32'h200,NOP,         32'h008,0,1);
        tbl[15] = mk(0,1,1,0,32'h0,  0,0,32'h0,        1,32'h204,32'h00300193,32'h200,1,0);
        tbl[16] = mk(0,0,0,0,32'h0,  0,0,32'h0,        1,32'h204,NOP,         32'h200,0,0);
        tbl[17] = mk(1,0,0,0,32'h0,  1,0,32'h0,        0,32'h204,NOP,         32'h200,0,0);

        rstN = 1'b0;
        drive_idle();
        imemGnt = 1'b1;
        @(negedge clk); @(negedge clk);
        #1 check_reset_vals("rst");

        @(negedge clk);
        rstN = 1'b1;
        for (int i = 0; i < 18; i++) begin
            stallF = tbl[i].sf; stallD = tbl[i].sd; flushD = tbl[i].fl;
            wrongBranchE = tbl[i].wb; pcTargetE = tbl[i].tgt;
            imemGnt = tbl[i].gnt; imemRvalid = tbl[i].rv; imemRdata = tbl[i].rd;
            #1;
            chk1 ($sformatf("tbl%0d.imemReq", i),    imemReq,    tbl[i].e_req);
            chk32($sformatf("tbl%0d.imemAddr", i),   imemAddr,   tbl[i].e_addr);
            chk32($sformatf("tbl%0d.instrD", i),     instrD,     tbl[i].e_instr);
            chk32($sformatf("tbl%0d.pcD", i),        pcD,        tbl[i].e_pc);
            chk32($sformatf("tbl%0d.pcPlus4D", i),   pcPlus4D,   tbl[i].e_pc + 32'd4);
            chk1 ($sformatf("tbl%0d.validD", i),     validD,     tbl[i].e_vld);
            chk1 ($sformatf("tbl%0d.fetchBusyF", i), fetchBusyF, tbl[i].e_busy);
            @(negedge clk);
        end

        // Reset asserted while a request is outstanding.
        drive_idle();
        imemGnt = 1'b1;
        #1 chk1("midrst.req_before", imemReq, 1'b1);
        @(negedge clk);
        imemGnt = 1'b0;
        #1 chk1("midrst.busy_before", fetchBusyF, 1'b1);
        #2 rstN = 1'b0;
        #1 check_reset_vals("midrst");
        @(negedge clk); @(negedge clk);
        rstN = 1'b1;
        #1;
        chk1 ("midrst.req_after",  imemReq,  1'b1);
        chk32("midrst.addr_after", imemAddr, 32'h0);

        // Randomized traffic against the model.
        model_reset();
        mem_pending = 1'b0;
        mem_cnt = 0;
        for (int c = 0; c < 800; c++) begin
            @(negedge clk);
            sf  = ($urandom_range(0, 5) == 0);
            sd  = ($urandom_range(0, 3) == 0);
            wb  = ($urandom_range(0, 11) == 0);
            fl  = wb || ($urandom_range(0, 19) == 0);
            tgt = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'hF))
                                              : ($urandom & 32'h0000_FFFF);
            gnt = ($urandom_range(0, 2) != 0);
            rv  = mem_pending && (mem_cnt == 0);
            rd  = $urandom;
            stallF = sf; stallD = sd; flushD = fl; wrongBranchE = wb; pcTargetE = tgt;
            imemGnt = gnt; imemRvalid = rv; imemRdata = rv ? rd : 32'h0;
            #1 check_model($sformatf("rnd%0d", c));
            fire_pred = model_req(sf) && gnt;
            model_step(sf, sd, fl, wb, tgt, gnt, rv, rd);
            if (rv) mem_pending = 1'b0;
            else if (mem_pending) mem_cnt--;
            if (fire_pred) begin
                mem_pending = 1'b1;
                mem_cnt = $urandom_range(0, 2);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
